// File: rtl/multicycle_controller_pkg.sv
// Shared encodings for the multicycle core control path: FSM states, opcodes and select codes.
package riscv_ctrl_pkg;

    localparam int unsigned STATE_W = 4;
    localparam int unsigned OP_W    = 7;
    localparam int unsigned SEL_W   = 2;

    typedef enum logic [STATE_W-1:0] {
        ST_FETCH    = 4'd0,
        ST_DECODE   = 4'd1,
        ST_MEMADR   = 4'd2,
        ST_MEMREAD  = 4'd3,
        ST_MEMWB    = 4'd4,
        ST_MEMWRITE = 4'd5,
        ST_EXECR    = 4'd6,
        ST_EXECI    = 4'd7,
        ST_ALUWB    = 4'd8,
        ST_BEQ      = 4'd9,
        ST_JAL      = 4'd10
    } state_t;

    localparam logic [OP_W-1:0] OP_LW   = 7'b0000011;
    localparam logic [OP_W-1:0] OP_SW   = 7'b0100011;
    localparam logic [OP_W-1:0] OP_R    = 7'b0110011;
    localparam logic [OP_W-1:0] OP_IALU = 7'b0010011;
    localparam logic [OP_W-1:0] OP_BEQ  = 7'b1100011;
    localparam logic [OP_W-1:0] OP_JAL  = 7'b1101111;

    localparam logic [SEL_W-1:0] ALUOP_ADD   = 2'b00;
    localparam logic [SEL_W-1:0] ALUOP_SUB   = 2'b01;
    localparam logic [SEL_W-1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [SEL_W-1:0] IMM_I = 2'b00;
    localparam logic [SEL_W-1:0] IMM_S = 2'b01;
    localparam logic [SEL_W-1:0] IMM_B = 2'b10;
    localparam logic [SEL_W-1:0] IMM_J = 2'b11;

    localparam logic [SEL_W-1:0] SRCA_PC    = 2'b00;
    localparam logic [SEL_W-1:0] SRCA_OLDPC = 2'b01;
    localparam logic [SEL_W-1:0] SRCA_RS1   = 2'b10;

    localparam logic [SEL_W-1:0] SRCB_RS2  = 2'b00;
    localparam logic [SEL_W-1:0] SRCB_IMM  = 2'b01;
    localparam logic [SEL_W-1:0] SRCB_FOUR = 2'b10;

    localparam logic [SEL_W-1:0] RES_ALUOUT    = 2'b00;
    localparam logic [SEL_W-1:0] RES_MEMDATA   = 2'b01;
    localparam logic [SEL_W-1:0] RES_ALURESULT = 2'b10;

endpackage

// File: rtl/multicycle_controller_if.sv
// Controller <-> datapath bundle: status inputs to the FSM and the control word it produces.
interface multicycle_controller_if;
    import riscv_ctrl_pkg::*;

    logic [OP_W-1:0]    op;
    logic               zero;
    logic               mem_ready;
    logic [SEL_W-1:0]   aluop;
    logic [SEL_W-1:0]   alusrca;
    logic [SEL_W-1:0]   alusrcb;
    logic [SEL_W-1:0]   resultsrc;
    logic [SEL_W-1:0]   immsrc;
    logic               adrsrc;
    logic               irwrite;
    logic               pcwrite;
    logic               regwrite;
    logic               memwrite;
    logic               illegal_op;
    logic [STATE_W-1:0] state;

    // Controller side
    modport master (
        input  op, zero, mem_ready,
        output aluop, alusrca, alusrcb, resultsrc, immsrc, adrsrc,
               irwrite, pcwrite, regwrite, memwrite, illegal_op, state
    );

    // Datapath side
    modport slave (
        output op, zero, mem_ready,
        input  aluop, alusrca, alusrcb, resultsrc, immsrc, adrsrc,
               irwrite, pcwrite, regwrite, memwrite, illegal_op, state
    );

endinterface

// File: rtl/multicycle_controller_instr_decoder.sv
// Immediate-format selection from the opcode; purely combinational.
module instr_decoder
    import riscv_ctrl_pkg::*;
(
    input  logic [OP_W-1:0]  op,
    output logic [SEL_W-1:0] immsrc
);

    // Map opcode to immediate format; unsupported opcodes fall back to I-format
    always_comb begin
        immsrc = IMM_I;
        case (op)
            OP_SW:   immsrc = IMM_S;
            OP_BEQ:  immsrc = IMM_B;
            OP_JAL:  immsrc = IMM_J;
            default: immsrc = IMM_I;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Main control FSM of the multicycle core: sequences fetch/decode/execute/memory/writeback.
module multicycle_controller
    import riscv_ctrl_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    multicycle_controller_if.master bus
);

    state_t             state_q;
    state_t             state_d;
    logic [SEL_W-1:0]   aluop;
    logic [SEL_W-1:0]   alusrca;
    logic [SEL_W-1:0]   alusrcb;
    logic [SEL_W-1:0]   resultsrc;
    logic [SEL_W-1:0]   immsrc;
    logic               adrsrc;
    logic               irload;
    logic               pcupdate;
    logic               branch;
    logic               regwrite;
    logic               memwrite;
    logic               illegal_op;

    instr_decoder u_instr_decoder (
        .op     (bus.op),
        .immsrc (immsrc)
    );

    // State register; reset abandons any instruction in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and Moore output decode, with mem_ready qualifying FETCH loads
    always_comb begin
        state_d    = state_q;
        aluop      = ALUOP_ADD;
        alusrca    = SRCA_PC;
        alusrcb    = SRCB_RS2;
        resultsrc  = RES_ALUOUT;
        adrsrc     = 1'b0;
        irload     = 1'b0;
        pcupdate   = 1'b0;
        branch     = 1'b0;
        regwrite   = 1'b0;
        memwrite   = 1'b0;
        illegal_op = 1'b0;
        case (state_q)
            ST_FETCH: begin
                alusrcb   = SRCB_FOUR;
                resultsrc = RES_ALURESULT;
                irload    = bus.mem_ready;
                pcupdate  = bus.mem_ready;
                if (bus.mem_ready) state_d = ST_DECODE;
            end
            ST_DECODE: begin
                alusrca = SRCA_OLDPC;
                alusrcb = SRCB_IMM;
                case (bus.op)
                    OP_LW, OP_SW: state_d = ST_MEMADR;
                    OP_R:         state_d = ST_EXECR;
                    OP_IALU:      state_d = ST_EXECI;
                    OP_BEQ:       state_d = ST_BEQ;
                    OP_JAL:       state_d = ST_JAL;
                    default: begin
                        state_d    = ST_FETCH;
                        illegal_op = 1'b1;
                    end
                endcase
            end
            ST_MEMADR: begin
                alusrca = SRCA_RS1;
                alusrcb = SRCB_IMM;
                state_d = (bus.op == OP_SW) ? ST_MEMWRITE : ST_MEMREAD;
            end
            ST_MEMREAD: begin
                adrsrc = 1'b1;
                if (bus.mem_ready) state_d = ST_MEMWB;
            end
            ST_MEMWB: begin
                resultsrc = RES_MEMDATA;
                regwrite  = 1'b1;
                state_d   = ST_FETCH;
            end
            ST_MEMWRITE: begin
                adrsrc   = 1'b1;
                memwrite = 1'b1;
                if (bus.mem_ready) state_d = ST_FETCH;
            end
            ST_EXECR: begin
                alusrca = SRCA_RS1;
                alusrcb = SRCB_RS2;
                aluop   = ALUOP_FUNCT;
                state_d = ST_ALUWB;
            end
            ST_EXECI: begin
                alusrca = SRCA_RS1;
                alusrcb = SRCB_IMM;
                aluop   = ALUOP_FUNCT;
                state_d = ST_ALUWB;
            end
            ST_ALUWB: begin
                regwrite = 1'b1;
                state_d  = ST_FETCH;
            end
            ST_BEQ: begin
                alusrca = SRCA_RS1;
                alusrcb = SRCB_RS2;
                aluop   = ALUOP_SUB;
                branch  = 1'b1;
                state_d = ST_FETCH;
            end
            ST_JAL: begin
                alusrca  = SRCA_OLDPC;
                alusrcb  = SRCB_FOUR;
                pcupdate = 1'b1;
                state_d  = ST_ALUWB;
            end
            default: begin
                state_d = ST_FETCH;
            end
        endcase
    end

    // Loads are masked while reset is held so a ready memory cannot load IR/PC
    assign bus.irwrite    = irload & rst_n;
    assign bus.pcwrite    = (pcupdate | (branch & bus.zero)) & rst_n;
    assign bus.aluop      = aluop;
    assign bus.alusrca    = alusrca;
    assign bus.alusrcb    = alusrcb;
    assign bus.resultsrc  = resultsrc;
    assign bus.immsrc     = immsrc;
    assign bus.adrsrc     = adrsrc;
    assign bus.regwrite   = regwrite;
    assign bus.memwrite   = memwrite;
    assign bus.illegal_op = illegal_op;
    assign bus.state      = STATE_W'(state_q);

endmodule
